pulse_shaper: RTL and testbench

Transmit-side counterpart of the input pulse-cleaning path.
- Accepts single-cycle event strobes from core logic.
- Regenerates each strobe as a wide, well-formed output pulse with a guaranteed high time and a guaranteed minimum low gap, suitable for a slow external receiver that synchronises and edge-detects it.
- Strobes that arrive while a pulse is in flight are queued in a saturating counter, so no event is lost until the queue saturates.

---
 rtl/pulse_shaper_pkg.sv | 20 ++
 rtl/sat_counter.sv | 37 +++
 rtl/pulse_shaper.sv | 128 ++++++++++++
 tb/tb_pulse_shaper.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_shaper_pkg.sv
// Shared definitions for the pulse shaper: FSM state encoding and the
// helper that sizes the phase timing counter.
package pulse_shaper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // Width of a down-counter that must hold max(hi, lo)-1; never below 1 bit.
  function automatic int cnt_width(input int hi, input int lo);
    int m;
    int w;
    m = (hi > lo) ? hi : lo;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up/down counter that saturates at all-ones and never wraps below zero.
// Simultaneous inc and dec cancel; an inc-only request at full is refused
// and reported on o_ovf in the same cycle so the caller can record the drop.
module sat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_ovf
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] r_cnt;
  logic         w_full;
  logic         w_empty;

  assign w_full  = (r_cnt == MAX);
  assign w_empty = (r_cnt == '0);
  assign o_ovf   = i_inc & ~i_dec & w_full;
  assign o_cnt   = r_cnt;

  // Count register: step up or down unless the bound would be crossed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && !w_full) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc && !w_empty) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/pulse_shaper.sv
// Turns single-cycle event strobes into wide pulses with a fixed high time
// and a guaranteed minimum low gap. Events arriving during a pulse are queued
// in a saturating pending counter; all outputs come from registered state.
module pulse_shaper
  import pulse_shaper_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              clr_ovf,
  output logic              out_pulse,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int CW = cnt_width(HIGH_CYCLES, LOW_CYCLES);
  localparam logic [CW-1:0] HI_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LO_LOAD = CW'(LOW_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic        r_out;
  logic        w_out_nxt;
  logic        r_ovf;
  logic        w_launch;
  logic        w_pend_nz;
  logic        w_req;
  logic        w_inc;
  logic        w_dec;
  logic        w_drop;
  logic [PEND_W-1:0] w_pending;

  assign w_pend_nz = (w_pending != '0);
  assign w_req     = pulse_in | w_pend_nz;

  // A launch takes a fresh strobe directly only when nothing is queued;
  // otherwise the strobe is queued and the oldest queued event is launched.
  assign w_inc = pulse_in & ~(w_launch & ~w_pend_nz);
  assign w_dec = w_launch & w_pend_nz;

  sat_counter #(
    .W (PEND_W)
  ) u_pend (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_inc),
    .i_dec (w_dec),
    .o_cnt (w_pending),
    .o_ovf (w_drop)
  );

  // Next-state, phase counter reload and launch decision.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_launch    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = HI_LOAD;
        end
      end
      ST_HIGH: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = LO_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_LOW: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (w_req) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = HI_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    w_out_nxt = (w_state_nxt == ST_HIGH);
  end

  // State, phase counter and registered output pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign out_pulse = r_out;
  assign busy      = (r_state != ST_IDLE);
  assign pending   = w_pending;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_pulse_shaper.sv
// Self-checking bench for pulse_shaper: a timeline model predicts pulse start
// cycles, pending depth, busy and overflow; start cycles are queued at stimulus
// time and popped when the DUT shows a rising output edge.
module tb_pulse_shaper;

  localparam int H    = 4;
  localparam int L    = 4;
  localparam int PW   = 3;
  localparam int PMAX = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          pulse_in;
  logic          clr_ovf;
  logic          out_pulse;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  logic          p1_in;
  logic          c1_clr = 1'b0;
  logic          out1;
  logic          busy1;
  logic [PW-1:0] pend1;
  logic          ovf1;

  pulse_shaper #(.HIGH_CYCLES(H), .LOW_CYCLES(L), .PEND_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .clr_ovf(clr_ovf),
    .out_pulse(out_pulse), .busy(busy), .pending(pending), .overflow(overflow)
  );

  pulse_shaper #(.HIGH_CYCLES(1), .LOW_CYCLES(1), .PEND_W(PW)) dut1 (
    .clk(clk), .rst_n(rst_n), .pulse_in(p1_in), .clr_ovf(c1_clr),
    .out_pulse(out1), .busy(busy1), .pending(pend1), .overflow(ovf1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base   = 0;
  int rises  = 0;

  int   acc_arr[$];
  int   acc_start[$];
  int   exp_q[$];
  int   next_free = 0;
  logic exp_ovf   = 1'b0;
  logic prev_out  = 1'b0;
  int   hi_cnt    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Timeline model: each accepted event starts at max(arrival+1, next free slot).
  always @(posedge clk) begin
    int   t;
    int   n;
    int   s;
    logic drop;
    if (!rst_n) begin
      acc_arr.delete();
      acc_start.delete();
      exp_q.delete();
      next_free = 0;
      exp_ovf   = 1'b0;
    end else begin
      t    = cyc;
      drop = 1'b0;
      if (pulse_in === 1'b1) begin
        n = 0;
        foreach (acc_start[i]) if (acc_start[i] > t + 1) n++;
        if (n >= PMAX) begin
          drop = 1'b1;
        end else begin
          s = (t + 1 > next_free) ? t + 1 : next_free;
          acc_arr.push_back(t);
          acc_start.push_back(s);
          exp_q.push_back(s);
          next_free = s + H + L;
        end
      end
      if (drop) exp_ovf = 1'b1;
      else if (clr_ovf === 1'b1) exp_ovf = 1'b0;
    end
  end

  // Monitor: compare every cycle against the model, pop starts on rising edges.
  always @(negedge clk) begin
    int            c;
    int            ep;
    logic          eb;
    logic [PW-1:0] epv;
    if (rst_n !== 1'b1) begin
      prev_out = 1'b0;
      hi_cnt   = 0;
    end else begin
      c  = cyc;
      ep = 0;
      eb = 1'b0;
      foreach (acc_start[i]) begin
        if (acc_arr[i] < c && acc_start[i] > c) ep++;
        if (acc_start[i] <= c && c < acc_start[i] + H + L) eb = 1'b1;
      end
      epv = PW'(ep);
      checks += 3;
      if (pending !== epv) begin
        errors++; $display("FAIL mon_pending cyc=%0d got %0d want %0d", c, pending, epv);
      end
      if (busy !== eb) begin
        errors++; $display("FAIL mon_busy cyc=%0d got %b want %b", c, busy, eb);
      end
      if (overflow !== exp_ovf) begin
        errors++; $display("FAIL mon_overflow cyc=%0d got %b want %b", c, overflow, exp_ovf);
      end
      if (out_pulse === 1'b1 && !prev_out) begin
        rises++;
        hi_cnt = 0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL mon_start cyc=%0d got rise want none", c);
        end else begin
          ep = exp_q.pop_front();
          if (ep != c) begin
            errors++; $display("FAIL mon_start got %0d want %0d", c, ep);
          end
        end
      end
      if (out_pulse === 1'b1) hi_cnt++;
      if (out_pulse !== 1'b1 && prev_out) begin
        checks++;
        if (hi_cnt != H) begin
          errors++; $display("FAIL mon_width got %0d want %0d", hi_cnt, H);
        end
      end
      prev_out = (out_pulse === 1'b1);
    end
  end

  task automatic step_to(input int rc);
    int guard;
    guard = 0;
    while (cyc - base < rc && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic set_origin();
    @(negedge clk);
    base = cyc;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && (busy !== 1'b0 || exp_q.size() != 0); i++) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL drain busy=%b left=%0d want busy=0 left=0", busy, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pulse_in = 1'b0; clr_ovf = 1'b0; p1_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base  = cyc;
    for (int c = 0; c < 20; c++) begin
      step_to(c);
      checks++;
      if ({out_pulse, busy, pending, overflow} !== '0) begin
        errors++; $display("FAIL reset_idle c=%0d got %b want 0", c, {out_pulse, busy, pending, overflow});
      end
    end
  endtask

  task automatic test_single();
    set_origin();
    for (int c = 0; c <= 20; c++) begin
      step_to(c);
      pulse_in = (c == 10);
      checks += 3;
      if (out_pulse !== (c >= 11 && c <= 14)) begin
        errors++; $display("FAIL single_out c=%0d got %b", c, out_pulse);
      end
      if (busy !== (c >= 11 && c <= 18)) begin
        errors++; $display("FAIL single_busy c=%0d got %b", c, busy);
      end
      if (pending !== '0) begin
        errors++; $display("FAIL single_pending c=%0d got %0d want 0", c, pending);
      end
    end
    pulse_in = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] ep;
    logic          eo;
    set_origin();
    for (int c = 0; c <= 36; c++) begin
      step_to(c);
      pulse_in = (c >= 10 && c <= 12);
      eo = (c >= 11 && c <= 14) || (c >= 19 && c <= 22) || (c >= 27 && c <= 30);
      ep = (c < 12) ? 3'd0 : (c == 12) ? 3'd1 : (c < 19) ? 3'd2 : (c < 27) ? 3'd1 : 3'd0;
      checks += 3;
      if (out_pulse !== eo) begin
        errors++; $display("FAIL b2b_out c=%0d got %b want %b", c, out_pulse, eo);
      end
      if (pending !== ep) begin
        errors++; $display("FAIL b2b_pending c=%0d got %0d want %0d", c, pending, ep);
      end
      if (busy !== (c >= 11 && c <= 34)) begin
        errors++; $display("FAIL b2b_busy c=%0d got %b", c, busy);
      end
    end
    pulse_in = 1'b0;
    drain();
  endtask

  task automatic test_saturate();
    int r0;
    set_origin();
    r0 = rises;
    for (int c = 0; c <= 25; c++) begin
      step_to(c);
      pulse_in = (c >= 10 && c <= 19);
      if (c == 17 || c == 18 || c == 19) begin
        checks++;
        if (pending !== ((c == 17) ? 3'd6 : 3'd7)) begin
          errors++; $display("FAIL sat_pending c=%0d got %0d", c, pending);
        end
      end
      if (c == 19 || c == 20) begin
        checks++;
        if (overflow !== (c == 20)) begin
          errors++; $display("FAIL sat_overflow c=%0d got %b want %b", c, overflow, (c == 20));
        end
      end
    end
    pulse_in = 1'b0;
    drain();
    checks++;
    if (rises - r0 != 9) begin
      errors++; $display("FAIL sat_pulse_count got %0d want 9", rises - r0);
    end
  endtask

  task automatic test_overflow_clear();
    set_origin();
    step_to(2);
    clr_ovf = 1'b1;
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL clr_before got %b want 1", overflow);
    end
    step_to(3);
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL clr_alone got %b want 0", overflow);
    end
    set_origin();
    for (int c = 0; c <= 24; c++) begin
      step_to(c);
      pulse_in = (c >= 10 && c <= 21);
      clr_ovf  = (c == 19);
      if (c == 19 || c == 20 || c == 22) begin
        checks++;
        if (overflow !== (c != 19)) begin
          errors++; $display("FAIL set_wins c=%0d got %b want %b", c, overflow, (c != 19));
        end
      end
    end
    pulse_in = 1'b0;
    clr_ovf  = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    set_origin();
    for (int c = 0; c <= 13; c++) begin
      step_to(c);
      pulse_in = (c >= 10 && c <= 12);
    end
    checks++;
    if ({out_pulse, pending, overflow} !== {1'b1, 3'd2, 1'b1}) begin
      errors++; $display("FAIL mid_pre got %b want 1_010_1", {out_pulse, pending, overflow});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_pulse, busy, pending, overflow} !== '0) begin
      errors++; $display("FAIL async_reset got %b want 0", {out_pulse, busy, pending, overflow});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base  = cyc;
    for (int c = 0; c <= 12; c++) begin
      step_to(c);
      pulse_in = (c == 1);
      checks += 2;
      if (out_pulse !== (c >= 2 && c <= 5)) begin
        errors++; $display("FAIL post_reset_out c=%0d got %b", c, out_pulse);
      end
      if (busy !== (c >= 2 && c <= 9)) begin
        errors++; $display("FAIL post_reset_busy c=%0d got %b", c, busy);
      end
    end
    pulse_in = 1'b0;
    drain();
  endtask

  task automatic test_short();
    set_origin();
    for (int c = 0; c <= 15; c++) begin
      step_to(c);
      p1_in = (c == 10);
      checks += 3;
      if (out1 !== (c == 11)) begin
        errors++; $display("FAIL short_out c=%0d got %b", c, out1);
      end
      if (busy1 !== (c == 11 || c == 12)) begin
        errors++; $display("FAIL short_busy c=%0d got %b", c, busy1);
      end
      if (pend1 !== '0) begin
        errors++; $display("FAIL short_pending c=%0d got %0d want 0", c, pend1);
      end
    end
    p1_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_saturate();
    test_overflow_clear();
    test_reset_mid();
    test_short();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
